// File: rtl/alu_share_arbiter_pkg.sv
// ALU share arbiter: shared constants, FSM states and ALU control decode.
// No ports; imported by the interface users and the arbiter top.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [2:0] FUNC_ADD    = 3'b000;
  localparam logic [2:0] FUNC_OR     = 3'b011;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_OR      = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [3:0] decode_alu_ctrl(
    input logic [1:0] aluop,
    input logic [2:0] func
  );
    logic [3:0] c;
    c = ALU_ADD;
    if (aluop == ALUOP_RTYPE) begin
      unique case (func)
        FUNC_ADD: c = ALU_ADD;
        FUNC_OR:  c = ALU_OR;
        default:  c = ALU_ADD;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// ALU share arbiter: request/response handshake bundle for two requesters.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [1:0]        req0_aluop;
  logic [2:0]        req0_func;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [1:0]        req1_aluop;
  logic [2:0]        req1_func;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;

  modport master (
    output req_valid, req0_a, req0_b,
    output req0_aluop, req0_func,
    output req1_a, req1_b,
    output req1_aluop, req1_func,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_zero
  );

  modport slave (
    input  req_valid, req0_a, req0_b,
    input  req0_aluop, req0_func,
    input  req1_a, req1_b,
    input  req1_aluop, req1_func,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: req[1:0], last_grant (index) -> one-hot grant.
// Purely combinational; on contention the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one EX ALU between pipeline EX (req0) and aux unit (req1).
// Ports: clk, reset, bus (slave handshake), alu_a/b/ctrl, alu_result/zero, busy.
module alu_share_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_arbiter_if.slave bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  state_t            state, state_nx;
  logic              last_grant;
  logic [1:0]        grant;
  logic [1:0]        owner;
  logic              accept;
  logic [1:0]        req_ready_c;
  logic [1:0]        rsp_valid_c;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_zero_q;

  rr_arb2 u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    state_nx    = state;
    req_ready_c = 2'b00;
    rsp_valid_c = 2'b00;
    accept      = 1'b0;
    unique case (state)
      IDLE: begin
        // ready is combinational; mask it while reset is held
        req_ready_c = reset ? 2'b00 : grant;
        accept      = |(bus.req_valid & grant);
        if (accept) state_nx = EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: begin
        rsp_valid_c = owner;
        if (|(owner & bus.rsp_ready))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 2'b00;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= 4'b0000;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner      <= grant;
        last_grant <= grant[1];
        // ALU ports are the operand latches: stable outside EXEC
        if (grant[1]) begin
          alu_a    <= bus.req1_a;
          alu_b    <= bus.req1_b;
          alu_ctrl <= decode_alu_ctrl(bus.req1_aluop,
                                      bus.req1_func);
        end else begin
          alu_a    <= bus.req0_a;
          alu_b    <= bus.req0_b;
          alu_ctrl <= decode_alu_ctrl(bus.req0_aluop,
                                      bus.req0_func);
        end
      end
      if (state == EXEC) begin
        rsp_data_q <= alu_result;
        rsp_zero_q <= alu_zero;
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed vector table plus
// hand sequences for stall, reset-in-EXEC and post-reset priority.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [3:0]    alu_ctrl;
  logic          alu_zero;
  logic          busy;

  int checks;
  int errors;

  alu_share_arbiter_if #(.DATA_W(W)) bus ();

  alu_share_arbiter #(.DATA_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  // reference ALU
  always_comb begin
    alu_result = '0;
    if (alu_ctrl == 4'b0010) alu_result = alu_a + alu_b;
    else if (alu_ctrl == 4'b0001) alu_result = alu_a | alu_b;
  end
  assign alu_zero = (alu_result == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, b0;
    logic [1:0]  op0;
    logic [2:0]  f0;
    logic [31:0] a1, b1;
    logic [1:0]  op1;
    logic [2:0]  f1;
    logic [1:0]  g;
    logic [3:0]  ctrl;
    logic [31:0] data;
    logic        z;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid  = v.req;
    bus.req0_a     = v.a0;
    bus.req0_b     = v.b0;
    bus.req0_aluop = v.op0;
    bus.req0_func  = v.f0;
    bus.req1_a     = v.a1;
    bus.req1_b     = v.b1;
    bus.req1_aluop = v.op1;
    bus.req1_func  = v.f1;
    bus.rsp_ready  = 2'b00;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    drive(v);
    #1 chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(v.g));
    @(posedge clk); #1;
    chk($sformatf("v%0d busy_exec", i), 32'(busy), 1);
    chk($sformatf("v%0d ready_exec", i), 32'(bus.req_ready), 0);
    chk($sformatf("v%0d alu_ctrl", i), 32'(alu_ctrl), 32'(v.ctrl));
    chk($sformatf("v%0d alu_a", i), alu_a, v.g[1] ? v.a1 : v.a0);
    chk($sformatf("v%0d alu_b", i), alu_b, v.g[1] ? v.b1 : v.b0);
    chk($sformatf("v%0d rsp_valid_exec", i), 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    chk($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(v.g));
    chk($sformatf("v%0d rsp_data", i), bus.rsp_data, v.data);
    chk($sformatf("v%0d rsp_zero", i), 32'(bus.rsp_zero), 32'(v.z));
    bus.rsp_ready = v.g;
    @(posedge clk); #1;
    chk($sformatf("v%0d busy_done", i), 32'(busy), 0);
    chk($sformatf("v%0d rsp_valid_done", i), 32'(bus.rsp_valid), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " req_ready"}, 32'(bus.req_ready), 0);
    chk({nm, " rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({nm, " rsp_data"}, bus.rsp_data, 0);
    chk({nm, " rsp_zero"}, 32'(bus.rsp_zero), 0);
    chk({nm, " alu_a"}, alu_a, 0);
    chk({nm, " alu_b"}, alu_b, 0);
    chk({nm, " alu_ctrl"}, 32'(alu_ctrl), 0);
    chk({nm, " busy"}, 32'(busy), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //        req   a0          b0  op0   f0      a1     b1     op1   f1      g     ctrl     data        z
    tv[0] = '{2'b01, 32'd5,     32'd7, 2'b10, 3'b000, 0,     0,     2'b00, 3'b000, 2'b01, 4'b0010, 32'd12,    1'b0};
    tv[1] = '{2'b11, 32'd1,     32'd2, 2'b10, 3'b000, 32'h13, 32'h21, 2'b10, 3'b011, 2'b10, 4'b0001, 32'h33,    1'b0};
    tv[2] = '{2'b11, 32'd1,     32'd2, 2'b10, 3'b000, 32'h13, 32'h21, 2'b10, 3'b011, 2'b01, 4'b0010, 32'd3,     1'b0};
    tv[3] = '{2'b11, 32'h7,     32'h9, 2'b00, 3'b011, 32'hA0, 32'h0A, 2'b10, 3'b000, 2'b10, 4'b0010, 32'hAA,    1'b0};
    tv[4] = '{2'b11, 32'h7,     32'h9, 2'b00, 3'b011, 32'hA0, 32'h0A, 2'b10, 3'b000, 2'b01, 4'b0010, 32'h10,    1'b0};
    tv[5] = '{2'b10, 0,         0,     2'b00, 3'b000, 32'hF0, 32'h0F, 2'b10, 3'b011, 2'b10, 4'b0001, 32'hFF,    1'b0};
    tv[6] = '{2'b10, 0,         0,     2'b00, 3'b000, 32'h100, 32'h23, 2'b00, 3'b011, 2'b10, 4'b0010, 32'h123, 1'b0};
    tv[7] = '{2'b01, 0,         0,     2'b01, 3'b000, 0,     0,     2'b00, 3'b000, 2'b01, 4'b0010, 32'd0,     1'b1};
    tv[8] = '{2'b01, 32'hFFFF_FFFF, 32'd1, 2'b10, 3'b111, 0, 0,     2'b00, 3'b000, 2'b01, 4'b0010, 32'd0,     1'b1};
    tv[9] = '{2'b11, 32'd1,     32'd1, 2'b10, 3'b000, 32'h0F0F, 32'hF000, 2'b11, 3'b011, 2'b10, 4'b0010, 32'hFF0F, 1'b0};

    reset          = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_aluop = 2'b00;
    bus.req0_func  = 3'b000;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_aluop = 2'b00;
    bus.req1_func  = 3'b000;
    bus.rsp_ready  = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("por");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, tv[i]);

    // response stall with non-owner ready ignored
    @(negedge clk);
    bus.req_valid  = 2'b01;
    bus.req0_a     = 32'd3;
    bus.req0_b     = 32'd4;
    bus.req0_aluop = 2'b10;
    bus.req0_func  = 3'b011;
    @(posedge clk); #1;
    chk("stall alu_ctrl", 32'(alu_ctrl), 32'h1);
    @(posedge clk); #1;
    chk("stall rsp_valid0", 32'(bus.rsp_valid), 32'h1);
    chk("stall rsp_data0", bus.rsp_data, 32'd7);
    bus.req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      bus.rsp_ready = (i == 2) ? 2'b10 : 2'b00;
      @(posedge clk); #1;
      chk("stall rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("stall rsp_data", bus.rsp_data, 32'd7);
      chk("stall rsp_zero", 32'(bus.rsp_zero), 0);
      chk("stall req_ready", 32'(bus.req_ready), 0);
      chk("stall busy", 32'(busy), 1);
    end
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    chk("release busy", 32'(busy), 0);
    chk("release rsp_valid", 32'(bus.rsp_valid), 0);
    chk("hold alu_ctrl", 32'(alu_ctrl), 32'h1);
    chk("hold alu_a", alu_a, 32'd3);

    // reset during EXEC aborts; req0 granted last before the reset
    @(negedge clk);
    bus.rsp_ready  = 2'b00;
    bus.req_valid  = 2'b01;
    bus.req0_a     = 32'd9;
    bus.req0_b     = 32'd9;
    bus.req0_aluop = 2'b10;
    bus.req0_func  = 3'b000;
    @(posedge clk); #1;
    chk("abort busy_exec", 32'(busy), 1);
    reset = 1'b1;
    #1 chk_all_zero("abort");
    bus.req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort no_rsp", 32'(bus.rsp_valid), 0);
      chk("abort idle", 32'(busy), 0);
    end

    // after reset, contention goes to req0
    @(negedge clk);
    bus.req_valid  = 2'b11;
    bus.req1_a     = 32'd100;
    bus.req1_b     = 32'd1;
    bus.req1_aluop = 2'b00;
    bus.req1_func  = 3'b000;
    #1 chk("postrst grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    chk("postrst rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("postrst rsp_data", bus.rsp_data, 32'd18);
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    chk("postrst busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
